// File: rtl/sm_stream_reader_if.sv
// Write-port and stream-out signal bundle for sm_stream_reader.
// The slave side is the reader block; the master side is the Sorter/consumer pair.
interface sm_stream_reader_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int LOG2_ELEMENT_NUM = 7
);
    logic                        SM_valid;
    logic [LOG2_ELEMENT_NUM-1:0] SM_addr;
    logic [DATA_WIDTH-1:0]       SM_data;
    logic                        done;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out_data;
    logic [LOG2_ELEMENT_NUM-1:0] out_idx;
    logic                        out_last;

    modport slave (
        input  SM_valid, SM_addr, SM_data, done, out_ready,
        output out_valid, out_data, out_idx, out_last
    );

    modport master (
        output SM_valid, SM_addr, SM_data, done, out_ready,
        input  out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/sm_stream_reader.sv
// Captures the Sorter's sorted-memory writes, then on the rising edge of done streams
// the whole store out in ascending address order over valid/ready.
module sm_stream_reader #(
    parameter int DATA_WIDTH       = 32,
    parameter int ELEMENT_NUM      = 128,
    parameter int LOG2_ELEMENT_NUM = 7
) (
    input  logic              clk_mn,
    input  logic              rst,
    sm_stream_reader_if.slave bus,
    output logic              busy,
    output logic              miss_err,
    output logic              wr_err
);
    localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_IDX = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic                        done_d;
    logic                        start;
    logic                        fill_wr;
    logic                        hshake;
    logic [ELEMENT_NUM-1:0]      written_q;
    logic [ELEMENT_NUM-1:0]      wr_onehot;
    logic [DATA_WIDTH-1:0]       store [ELEMENT_NUM];
    logic                        valid_q;
    logic                        last_q;
    logic [LOG2_ELEMENT_NUM-1:0] idx_q;
    logic [LOG2_ELEMENT_NUM-1:0] nxt_idx;
    logic [DATA_WIDTH-1:0]       data_q;

    assign fill_wr = bus.SM_valid && (state_q == FILL);
    assign hshake  = valid_q && bus.out_ready;
    assign nxt_idx = idx_q + 1'b1;
    assign busy    = (state_q == DRAIN);

    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;

    always_comb begin
        wr_onehot = '0;
        if (fill_wr) wr_onehot[bus.SM_addr] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            FILL: begin
                if (bus.done && !done_d) begin
                    state_d = DRAIN;
                    start   = 1'b1;
                end
            end
            DRAIN: begin
                if (hshake && last_q) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Store is deliberately outside the reset domain; only the bitmap tracks validity.
    always_ff @(posedge clk_mn) begin
        if (fill_wr) store[bus.SM_addr] <= bus.SM_data;
    end

    always_ff @(posedge clk_mn or negedge rst) begin
        if (!rst) begin
            state_q   <= FILL;
            done_d    <= 1'b0;
            written_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            miss_err  <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_d    <= bus.done;
            written_q <= written_q | wr_onehot;
            if (bus.SM_valid && state_q == DRAIN) wr_err <= 1'b1;

            if (start) begin
                valid_q <= 1'b1;
                idx_q   <= '0;
                last_q  <= (LAST_IDX == '0);
                // The done-edge cycle write has not reached the store yet; forward it.
                data_q  <= (fill_wr && bus.SM_addr == '0) ? bus.SM_data : store[0];
                if (!(&(written_q | wr_onehot))) miss_err <= 1'b1;
            end else if (state_q == DRAIN && hshake) begin
                if (last_q) begin
                    valid_q   <= 1'b0;
                    last_q    <= 1'b0;
                    idx_q     <= '0;
                    written_q <= '0;
                end else begin
                    idx_q  <= nxt_idx;
                    data_q <= store[nxt_idx];
                    last_q <= (nxt_idx == LAST_IDX);
                end
            end
        end
    end
endmodule

// File: tb/tb_sm_stream_reader.sv
// Directed bench for sm_stream_reader: fill/drain, stalls, missing address,
// forwarding on the done edge, write-during-drain and mid-drain async reset.
module tb_sm_stream_reader;
    localparam int DW  = 32;
    localparam int EN  = 128;
    localparam int LG  = 7;

    logic clk_mn = 1'b0;
    logic rst    = 1'b0;
    logic busy, miss_err, wr_err;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [DW-1:0] exp_mem [EN];

    sm_stream_reader_if #(.DATA_WIDTH(DW), .LOG2_ELEMENT_NUM(LG)) sif ();

    sm_stream_reader #(.DATA_WIDTH(DW), .ELEMENT_NUM(EN), .LOG2_ELEMENT_NUM(LG)) dut (
        .clk_mn  (clk_mn),
        .rst     (rst),
        .bus     (sif.slave),
        .busy    (busy),
        .miss_err(miss_err),
        .wr_err  (wr_err)
    );

    always #5 clk_mn = ~clk_mn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_mn);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_idx", sif.out_idx, 0);
        chk("rst_last", sif.out_last, 0);
        chk("rst_data", sif.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miss", miss_err, 0);
        chk("rst_wr", wr_err, 0);
        rst = 1'b1;
        tick();
    endtask

    task automatic fill(input int skip);
        for (int i = 0; i < EN; i++) begin
            if (i != skip) begin
                sif.SM_valid = 1'b1;
                sif.SM_addr  = LG'(i);
                sif.SM_data  = 32'h1000 + i;
                exp_mem[i]   = 32'h1000 + i;
                tick();
            end
        end
        sif.SM_valid = 1'b0;
    endtask

    task automatic start_drain(input bit fwd, input bit hold, input bit exp_miss);
        sif.done = 1'b1;
        if (fwd) begin
            sif.SM_valid = 1'b1;
            sif.SM_addr  = '0;
            sif.SM_data  = 32'hBEEF;
            exp_mem[0]   = 32'hBEEF;
        end
        tick();
        sif.SM_valid = 1'b0;
        if (!hold) sif.done = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_miss", miss_err, exp_miss);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating
    task automatic drain(input int mode, input bit inj, input int stop_at);
        int k   = 0;
        int cyc = 0;
        bit rdy;
        while (k < EN && cyc < 1000 && !(stop_at >= 0 && k == stop_at)) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            sif.out_ready = rdy;
            if (inj) begin
                sif.SM_valid = (cyc == 2);
                sif.SM_addr  = LG'(3);
                sif.SM_data  = 32'hDEAD;
            end
            chk("d_valid", sif.out_valid, 1);
            chk("d_idx", sif.out_idx, k);
            chk("d_data", sif.out_data, exp_mem[k]);
            chk("d_last", sif.out_last, (k == EN - 1));
            if (rdy) k++;
            cyc++;
            tick();
        end
        sif.SM_valid  = 1'b0;
        sif.out_ready = 1'b0;
        if (stop_at < 0) begin
            chk("d_count", k, EN);
            chk("d_cycles", cyc, (mode == 0) ? EN : 2 * EN);
            chk("end_valid", sif.out_valid, 0);
            chk("end_last", sif.out_last, 0);
            chk("end_busy", busy, 0);
        end
    endtask

    initial begin
        sif.SM_valid  = 1'b0;
        sif.SM_addr   = '0;
        sif.SM_data   = '0;
        sif.done      = 1'b0;
        sif.out_ready = 1'b0;

        // 1: full fill, free-running drain; done held high must not retrigger
        do_reset();
        fill(-1);
        start_drain(1'b0, 1'b1, 1'b0);
        drain(0, 1'b0, -1);
        tick(); tick(); tick();
        chk("t1_no_retrig", busy, 0);
        chk("t1_no_retrig_v", sif.out_valid, 0);
        chk("t1_miss", miss_err, 0);
        sif.done = 1'b0;
        tick();

        // 2: stalled drain
        fill(-1);
        start_drain(1'b0, 1'b0, 1'b0);
        drain(1, 1'b0, -1);

        // 3: address 5 never written this batch; store keeps 0x1005 from before
        do_reset();
        fill(5);
        start_drain(1'b0, 1'b0, 1'b1);
        drain(0, 1'b0, -1);
        chk("t3_miss_sticky", miss_err, 1);

        // 4: overwrite addr 0, then forward the done-edge write
        do_reset();
        sif.SM_valid = 1'b1;
        sif.SM_addr  = '0;
        sif.SM_data  = 32'hAAAA;
        tick();
        sif.SM_valid = 1'b0;
        fill(0);
        start_drain(1'b1, 1'b0, 1'b0);
        drain(0, 1'b0, -1);

        // 5: write during drain is dropped and flagged
        do_reset();
        fill(-1);
        start_drain(1'b0, 1'b0, 1'b0);
        drain(0, 1'b1, -1);
        chk("t5_wr_err", wr_err, 1);

        // 6: async reset mid-drain, then a clean restart
        fill(-1);
        start_drain(1'b0, 1'b0, 1'b0);
        drain(0, 1'b0, 60);
        chk("t6_at60", sif.out_idx, 60);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_valid", sif.out_valid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_idx", sif.out_idx, 0);
        chk("t6_async_wr", wr_err, 0);
        tick();
        rst = 1'b1;
        tick();
        fill(-1);
        start_drain(1'b0, 1'b0, 1'b0);
        drain(0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
